// File: rtl/reduction_eject_mux.sv
// Local-port ejection stage: per-port input FIFOs, parallel non-reduction ejection and a
// round-robin fed three-stage read-modify-write reduction table with same-index bypass.
module reduction_eject_mux #(
  parameter int NumPorts        = 7,
  parameter int DataWidth       = 256,
  parameter int FIFODepth       = 4,
  parameter int ReductionBitPos = 254,
  parameter int PayloadLen      = 128,
  parameter int IndexPos        = 128,
  parameter int IndexWidth      = 8,
  parameter int WeightPos       = 144,
  parameter int WeightWidth     = 8,
  parameter int CntWidth        = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumPorts*DataWidth-1:0] in_data,
  input  logic [NumPorts-1:0]           in_stall,
  output logic [NumPorts-1:0]           in_avail,
  output logic [NumPorts*DataWidth-1:0] out_data,
  output logic [DataWidth-1:0]          reduction_out,
  output logic                          reduction_send,
  input  logic                          cfg_we,
  input  logic [IndexWidth-1:0]         cfg_index,
  input  logic [CntWidth-1:0]           cfg_expect
);
  localparam int AW        = $clog2(FIFODepth);
  localparam int PW        = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int TableSize = 1 << IndexWidth;

  typedef struct packed {
    logic [CntWidth-1:0]    exp_cnt;
    logic [CntWidth-1:0]    count;
    logic [WeightWidth-1:0] weight;
    logic [PayloadLen-1:0]  payload;
  } entry_t;

  // Sums wrap modulo their field widths; no saturation.
  function automatic entry_t accumulate(input entry_t e, input logic [DataWidth-1:0] pkt);
    entry_t r;
    r.exp_cnt = e.exp_cnt;
    r.count   = e.count + CntWidth'(1);
    r.weight  = e.weight + pkt[WeightPos +: WeightWidth];
    r.payload = e.payload + pkt[PayloadLen-1:0];
    return r;
  endfunction

  function automatic logic is_complete(input entry_t e);
    return ({1'b0, e.count} + (CntWidth+1)'(1)) >= {1'b0, e.exp_cnt};
  endfunction

  function automatic entry_t fresh_entry(input logic [CntWidth-1:0] exp_cnt);
    entry_t r;
    r         = '0;
    r.exp_cnt = exp_cnt;
    return r;
  endfunction

  logic [DataWidth-1:0] head [NumPorts];
  logic [NumPorts-1:0]  red_req;
  logic                 grant_vld;
  logic [PW-1:0]        grant;
  logic [PW-1:0]        rr_ptr;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    logic [DataWidth-1:0] mem [FIFODepth];
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_ptr;
    logic [AW:0]          cnt;
    logic [DataWidth-1:0] slice;
    logic [DataWidth-1:0] ej;
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;

    assign slice       = in_data[p*DataWidth +: DataWidth];
    assign head[p]     = mem[rd_ptr];
    assign empty       = (cnt == '0);
    assign full        = (cnt == (AW+1)'(FIFODepth));
    assign red_req[p]  = !empty && head[p][ReductionBitPos];
    assign pop         = !empty && (!head[p][ReductionBitPos] || (grant_vld && grant == PW'(p)));
    // A full FIFO still accepts a push in the cycle its head leaves.
    assign push        = !in_stall[p] && slice[DataWidth-1] && (!full || pop);
    assign in_avail[p] = !full;
    assign out_data[p*DataWidth +: DataWidth] = ej;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
        ej     <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      cnt <= cnt + (AW+1)'(1);
        else if (pop && !push) cnt <= cnt - (AW+1)'(1);
        ej <= (!empty && !head[p][ReductionBitPos]) ? head[p] : '0;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= slice;
    end
  end

  // Round-robin search from rr_ptr upward; the downward loop leaves the nearest requester.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      if (red_req[PW'((int'(rr_ptr) + i) % NumPorts)]) begin
        grant_vld = 1'b1;
        grant     = PW'((int'(rr_ptr) + i) % NumPorts);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            rr_ptr <= '0;
    else if (grant_vld) rr_ptr <= (grant == PW'(NumPorts - 1)) ? '0 : grant + PW'(1);
  end

  logic                  vld_p0;
  logic                  vld_p1;
  logic [DataWidth-1:0]  pkt_p0;
  logic [DataWidth-1:0]  pkt_p1;
  logic [IndexWidth-1:0] idx_p0;
  logic [IndexWidth-1:0] idx_p1;
  entry_t                tbl [TableSize];
  entry_t                rd_p0;
  entry_t                ent_p1;
  entry_t                acc_p1;
  entry_t                wr_p1;
  entry_t                cfg_ent;
  logic                  done_p1;
  logic [DataWidth-1:0]  red_p1;

  assign idx_p0  = pkt_p0[IndexPos +: IndexWidth];
  assign idx_p1  = pkt_p1[IndexPos +: IndexWidth];
  assign cfg_ent = fresh_entry(cfg_expect);

  // S1 -> S2: granted head enters the pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= grant_vld;
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    pkt_p0 <= head[grant];
    pkt_p1 <= pkt_p0;
    ent_p1 <= rd_p0;
  end

  // S2: table read with bypass of this cycle's writes; config has the last word.
  always_comb begin
    rd_p0 = tbl[idx_p0];
    if (vld_p1 && idx_p1 == idx_p0)  rd_p0 = wr_p1;
    if (cfg_we && cfg_index == idx_p0) rd_p0 = cfg_ent;
  end

  // S2 -> S3: accumulate, write back, emit
  assign acc_p1  = accumulate(ent_p1, pkt_p1);
  assign done_p1 = is_complete(ent_p1);
  assign wr_p1   = done_p1 ? fresh_entry(ent_p1.exp_cnt) : acc_p1;

  always_comb begin
    red_p1                             = pkt_p1;
    red_p1[PayloadLen-1:0]             = acc_p1.payload;
    red_p1[WeightPos +: WeightWidth]   = acc_p1.weight;
  end

  always_ff @(posedge clk) begin
    if (vld_p1 && !rst && !(cfg_we && cfg_index == idx_p1)) tbl[idx_p1] <= wr_p1;
    if (cfg_we) tbl[cfg_index] <= cfg_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) reduction_out <= '0;
    else     reduction_out <= (vld_p1 && done_p1) ? red_p1 : '0;
  end

  assign reduction_send = reduction_out[DataWidth-1];

endmodule

// File: tb/tb_reduction_eject_mux.sv
// Bench for reduction_eject_mux: directed scenarios plus random traffic, every cycle
// checked against a queue-based model of FIFOs, round-robin grant and a sequential table.
module tb_reduction_eject_mux;
  localparam int NP = 7, DW = 256, DEPTH = 4, RB = 254, PL = 128;
  localparam int IP = 128, IW = 8, WP = 144, WW = 8, CW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*DW-1:0]  in_data;
  logic [NP-1:0]     in_stall;
  logic [NP-1:0]     in_avail;
  logic [NP*DW-1:0]  out_data;
  logic [DW-1:0]     reduction_out;
  logic              reduction_send;
  logic              cfg_we;
  logic [IW-1:0]     cfg_index;
  logic [CW-1:0]     cfg_expect;

  reduction_eject_mux dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_stall(in_stall), .in_avail(in_avail),
    .out_data(out_data), .reduction_out(reduction_out), .reduction_send(reduction_send),
    .cfg_we(cfg_we), .cfg_index(cfg_index), .cfg_expect(cfg_expect)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] pkt;
    int            due;
  } pend_t;

  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  logic [DW-1:0]  mq [NP][$];
  pend_t          pend [$];
  int             m_rr = 0;
  int             m_exp [256];
  int             m_cnt [256];
  logic [WW-1:0]  m_wt [256];
  logic [PL-1:0]  m_pl [256];
  logic [DW-1:0]  exp_out [NP];
  logic [DW-1:0]  exp_red;
  logic [NP-1:0]  exp_avail;
  logic [DW-1:0]  emits [$];

  function automatic logic [DW-1:0] mk(bit red, int idx, int wt, logic [PL-1:0] pl, int tag);
    logic [DW-1:0] d = '0;
    d[DW-1]    = 1'b1;
    d[RB]      = red;
    d[IP +: IW] = IW'(idx);
    d[WP +: WW] = WW'(wt);
    d[PL-1:0]  = pl;
    d[200 +: 8] = 8'(tag);
    return d;
  endfunction

  task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic put(int p, logic [DW-1:0] d);
    in_data[p*DW +: DW] = d;
  endtask

  task automatic apply_cfg();
    m_exp[cfg_index] = int'(cfg_expect);
    m_cnt[cfg_index] = 0;
    m_wt[cfg_index]  = '0;
    m_pl[cfg_index]  = '0;
  endtask

  // One cycle of the reference: a packet's table effect lands two cycles after its grant,
  // ahead of any config write in that same cycle; the table itself is updated sequentially.
  task automatic model_cycle();
    bit            popped [NP];
    bit            is_red [NP];
    bit            has [NP];
    int            g, q, i, c;
    logic [DW-1:0] d;
    logic [WW-1:0] w;
    logic [PL-1:0] pl;
    pend_t         pe;
    exp_red = '0;
    for (int p = 0; p < NP; p++) exp_out[p] = '0;
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        mq[p].delete();
        exp_avail[p] = 1'b1;
      end
      pend.delete();
      m_rr = 0;
      if (cfg_we) apply_cfg();
      return;
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      d = pend[0].pkt;
      pend.pop_front();
      i  = int'(d[IP +: IW]);
      c  = m_cnt[i] + 1;
      w  = m_wt[i] + d[WP +: WW];
      pl = m_pl[i] + d[PL-1:0];
      if (c >= m_exp[i]) begin
        exp_red = d;
        exp_red[PL-1:0]  = pl;
        exp_red[WP +: WW] = w;
        m_cnt[i] = 0;
        m_wt[i]  = '0;
        m_pl[i]  = '0;
      end else begin
        m_cnt[i] = c;
        m_wt[i]  = w;
        m_pl[i]  = pl;
      end
    end
    if (cfg_we) apply_cfg();
    for (int p = 0; p < NP; p++) begin
      has[p] = mq[p].size() > 0;
      is_red[p] = 1'b0;
      popped[p] = 1'b0;
      if (has[p]) is_red[p] = mq[p][0][RB];
      if (has[p] && !is_red[p]) begin
        exp_out[p] = mq[p].pop_front();
        popped[p]  = 1'b1;
      end
    end
    g = -1;
    for (int k = 0; k < NP; k++) begin
      q = (m_rr + k) % NP;
      if (g < 0 && is_red[q]) g = q;
    end
    if (g >= 0) begin
      pe.pkt = mq[g].pop_front();
      pe.due = cyc + 2;
      pend.push_back(pe);
      popped[g] = 1'b1;
      m_rr = (g + 1) % NP;
    end
    for (int p = 0; p < NP; p++) begin
      d = in_data[p*DW +: DW];
      if (d[DW-1] && !in_stall[p] && (mq[p].size() < DEPTH || popped[p])) mq[p].push_back(d);
      exp_avail[p] = mq[p].size() < DEPTH;
    end
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++)
      chk($sformatf("out_data[%0d] cyc %0d", p, cyc), out_data[p*DW +: DW], exp_out[p]);
    chk($sformatf("reduction_out cyc %0d", cyc), reduction_out, exp_red);
    chk($sformatf("reduction_send cyc %0d", cyc), DW'(reduction_send), DW'(exp_red[DW-1]));
    chk($sformatf("in_avail cyc %0d", cyc), DW'(in_avail), DW'(exp_avail));
    if (reduction_send) emits.push_back(reduction_out);
    cyc++;
    in_data  = '0;
    in_stall = '0;
    cfg_we   = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic set_cfg(int idx, int e);
    cfg_we     = 1'b1;
    cfg_index  = IW'(idx);
    cfg_expect = CW'(e);
    step();
  endtask

  task automatic drain(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    logic [DW-1:0] pk;
    bit            seen_full;
    in_data = '0; in_stall = '0; cfg_we = 1'b0; cfg_index = '0; cfg_expect = '0;
    rst = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk("reset in_avail", DW'(in_avail), DW'(7'h7F));
    chk("reset reduction_out", reduction_out, '0);
    chk("reset out_data[3]", out_data[3*DW +: DW], '0);
    for (int k = 0; k < 16; k++) set_cfg(k, k % 8);

    // Single non-reduction packet on port 3
    pk = mk(1'b0, 0, 0, 128'h1234_5678_9abc, 3);
    put(3, pk);
    step();
    step();
    chk("t1 out_data[3]", out_data[3*DW +: DW], pk);
    chk("t1 out_data[2]", out_data[2*DW +: DW], '0);
    chk("t1 reduction_send", DW'(reduction_send), '0);
    drain(2);

    // Three-way reduction to index 5
    set_cfg(5, 3);
    emits.delete();
    put(1, mk(1'b1, 5, 1, 10, 1));
    put(2, mk(1'b1, 5, 1, 20, 2));
    put(4, mk(1'b1, 5, 1, 30, 4));
    step();
    drain(8);
    chk("t2 emit count", DW'(emits.size()), DW'(1));
    chk("t2 payload", DW'(emits[0][PL-1:0]), DW'(60));
    chk("t2 weight", DW'(emits[0][WP +: WW]), DW'(3));
    chk("t2 last grant tag", DW'(emits[0][200 +: 8]), DW'(4));
    emits.delete();
    for (int k = 1; k <= 3; k++) begin
      put(0, mk(1'b1, 5, 2, k, 0));
      step();
    end
    drain(6);
    chk("t2 rearm count", DW'(emits.size()), DW'(1));
    chk("t2 rearm payload", DW'(emits[0][PL-1:0]), DW'(6));
    chk("t2 rearm weight", DW'(emits[0][WP +: WW]), DW'(6));

    // Back-to-back same index with payload wrap
    set_cfg(6, 2);
    emits.delete();
    put(0, mk(1'b1, 6, 0, {PL{1'b1}}, 0));
    step();
    put(0, mk(1'b1, 6, 0, 2, 0));
    step();
    drain(6);
    chk("t3 emit count", DW'(emits.size()), DW'(1));
    chk("t3 payload", DW'(emits[0][PL-1:0]), DW'(1));

    // Fairness between ports 0 and 6
    set_cfg(7, 1);
    emits.delete();
    for (int k = 0; k < 4; k++) begin
      put(0, mk(1'b1, 7, 0, 0, 0));
      put(6, mk(1'b1, 7, 0, 0, 6));
      step();
    end
    drain(12);
    chk("t4 emit count", DW'(emits.size()), DW'(8));
    for (int k = 1; k < 8 && k < emits.size(); k++)
      chk($sformatf("t4 alternate %0d", k), DW'(emits[k][200 +: 8] != emits[k-1][200 +: 8]), DW'(1));

    // Port 2 overfilled while six other ports compete for the arbiter
    set_cfg(8, 7);
    seen_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < NP; p++) if (p != 2) put(p, mk(1'b1, 8, 1, k, p));
      step();
    end
    for (int k = 0; k < 5; k++) begin
      put(2, mk(1'b1, 8, 1, 100 + k, 2));
      step();
      if (!in_avail[2]) seen_full = 1'b1;
    end
    chk("t5 port2 became full", DW'(seen_full), DW'(1));
    drain(50);

    // Config write landing on the S3 write of the same index
    set_cfg(9, 2);
    emits.delete();
    put(0, mk(1'b1, 9, 0, 1000, 0));
    step();
    step();
    step();
    set_cfg(9, 2);
    put(0, mk(1'b1, 9, 0, 5, 0));
    step();
    put(0, mk(1'b1, 9, 0, 7, 0));
    step();
    drain(8);
    chk("t6 emit count", DW'(emits.size()), DW'(1));
    chk("t6 payload", DW'(emits[0][PL-1:0]), DW'(12));

    // Reset while a reduction is in flight
    set_cfg(10, 1);
    emits.delete();
    put(0, mk(1'b1, 10, 0, 77, 0));
    step();
    step();
    rst = 1'b1;
    step();
    drain(6);
    chk("t7 no emit after reset", DW'(emits.size()), DW'(0));
    chk("t7 in_avail", DW'(in_avail), DW'(7'h7F));

    // Random traffic, including pushes against a full FIFO, stalls and resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(63) == 0) rst = 1'b1;
      if ($urandom_range(7) == 0) begin
        cfg_we     = 1'b1;
        cfg_index  = IW'($urandom_range(7));
        cfg_expect = CW'($urandom_range(7));
      end
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(2) == 0) begin
          put(p, mk(1'($urandom_range(1)), int'($urandom_range(7)), int'($urandom_range(255)),
                    {$urandom, $urandom, $urandom, $urandom}, p));
          if ($urandom_range(3) == 0) in_stall[p] = 1'b1;
          if ($urandom_range(7) == 0) in_data[p*DW + DW - 1] = 1'b0;
        end
      end
      step();
    end
    drain(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
